// File: rtl/stb_commit_cache.sv
// Direct-mapped, write-back, write-allocate cache answering store-buffer commits.
// Misses run a writeback/refill FSM against a line-wide memory port.
module stb_commit_cache #(
  parameter int VA_WIDTH   = 32,
  parameter int N_SETS     = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [2*VA_WIDTH:0]            i_commit,
  output logic                           o_hit,
  output logic                           o_load,
  input  logic [VA_WIDTH-1:0]            i_rd_addr,
  output logic                           o_rd_hit,
  output logic [VA_WIDTH-1:0]            o_rd_data,
  output logic                           o_mem_req,
  output logic                           o_mem_we,
  output logic [VA_WIDTH-1:0]            o_mem_addr,
  output logic [LINE_WORDS*VA_WIDTH-1:0] o_mem_wdata,
  input  logic                           i_mem_ack,
  input  logic [LINE_WORDS*VA_WIDTH-1:0] i_mem_rdata
);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int IDX_W  = $clog2(N_SETS);
  localparam int OFF_W  = WSEL_W + 2;
  localparam int TAG_W  = VA_WIDTH - OFF_W - IDX_W;

  typedef enum logic [1:0] {IDLE, WB, FILL} state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic                r_valid [N_SETS];
  logic                r_dirty [N_SETS];
  logic [TAG_W-1:0]    r_tag   [N_SETS];
  logic [VA_WIDTH-1:0] r_data  [N_SETS][LINE_WORDS];
  logic [VA_WIDTH-1:0] r_lineAddr;

  // i_commit is the packed mem_data_t: {enable, address, data}, enable in the MSB.
  logic                w_cEn;
  logic [VA_WIDTH-1:0] w_cAddr;
  logic [VA_WIDTH-1:0] w_cData;
  logic [WSEL_W-1:0]   w_cWord;
  logic [IDX_W-1:0]    w_cIdx;
  logic [TAG_W-1:0]    w_cTag;
  logic                w_cHit;
  logic                w_cMiss;
  logic [IDX_W-1:0]    w_vIdx;
  logic [LINE_WORDS*VA_WIDTH-1:0] w_victimLine;
  logic [WSEL_W-1:0]   w_rWord;
  logic [IDX_W-1:0]    w_rIdx;
  logic [TAG_W-1:0]    w_rTag;
  logic                w_unused;

  assign w_cEn   = i_commit[2*VA_WIDTH];
  assign w_cAddr = i_commit[VA_WIDTH +: VA_WIDTH];
  assign w_cData = i_commit[0 +: VA_WIDTH];
  assign w_cWord = w_cAddr[2 +: WSEL_W];
  assign w_cIdx  = w_cAddr[OFF_W +: IDX_W];
  assign w_cTag  = w_cAddr[VA_WIDTH-1 -: TAG_W];
  assign w_cHit  = (r_state == IDLE) && w_cEn && r_valid[w_cIdx] && (r_tag[w_cIdx] == w_cTag);
  assign w_cMiss = (r_state == IDLE) && w_cEn && !(r_valid[w_cIdx] && (r_tag[w_cIdx] == w_cTag));
  assign w_vIdx  = r_lineAddr[OFF_W +: IDX_W];

  assign w_unused = &{1'b0, w_cAddr[1:0], i_rd_addr[1:0]};

  always_comb begin
    w_victimLine = '0;
    for (int w = 0; w < LINE_WORDS; w++) begin
      w_victimLine[w*VA_WIDTH +: VA_WIDTH] = r_data[w_vIdx][w];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    o_hit       = 1'b0;
    o_load      = 1'b0;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    case (r_state)
      IDLE: begin
        o_hit  = w_cHit;
        o_load = w_cMiss;
        if (w_cMiss) begin
          w_nextState = (r_valid[w_cIdx] && r_dirty[w_cIdx]) ? WB : FILL;
        end
      end
      WB: begin
        o_load      = 1'b1;
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = {r_tag[w_vIdx], w_vIdx, {OFF_W{1'b0}}};
        o_mem_wdata = w_victimLine;
        if (i_mem_ack) w_nextState = FILL;
      end
      FILL: begin
        o_load     = 1'b1;
        o_mem_req  = 1'b1;
        o_mem_addr = r_lineAddr;
        if (i_mem_ack) w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The miss target keeps coming from r_lineAddr, so a changing commit cannot redirect a refill.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < N_SETS; s++) begin
        r_valid[s] <= 1'b0;
        r_dirty[s] <= 1'b0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cHit) begin
            r_data[w_cIdx][w_cWord] <= w_cData;
            r_dirty[w_cIdx]         <= 1'b1;
          end else if (w_cMiss) begin
            r_lineAddr <= {w_cAddr[VA_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
          end
        end
        WB: begin
          if (i_mem_ack) r_dirty[w_vIdx] <= 1'b0;
        end
        FILL: begin
          if (i_mem_ack) begin
            for (int w = 0; w < LINE_WORDS; w++) begin
              r_data[w_vIdx][w] <= i_mem_rdata[w*VA_WIDTH +: VA_WIDTH];
            end
            r_tag[w_vIdx]   <= r_lineAddr[VA_WIDTH-1 -: TAG_W];
            r_valid[w_vIdx] <= 1'b1;
            r_dirty[w_vIdx] <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign w_rWord   = i_rd_addr[2 +: WSEL_W];
  assign w_rIdx    = i_rd_addr[OFF_W +: IDX_W];
  assign w_rTag    = i_rd_addr[VA_WIDTH-1 -: TAG_W];
  assign o_rd_hit  = r_valid[w_rIdx] && (r_tag[w_rIdx] == w_rTag);
  assign o_rd_data = o_rd_hit ? r_data[w_rIdx][w_rWord] : '0;

endmodule

// File: doc/stb_commit_cache.md
Name: stb_commit_cache

Overview:
- Store-side responder for the store buffer's commit interface: a direct-mapped, write-back, write-allocate data cache array.
- Accepts the oldest buffered store on i_commit and answers with o_hit and o_load, which the store buffer registers to decide when to pop.
- On a miss it runs a writeback/refill FSM against a line-wide memory port.
- Exposes a combinational word read port for the load path and for verification.

Parameters:
- VA_WIDTH, 32, address and data word width (matches mem_data_t).
- N_SETS, 16, number of direct-mapped lines; power of two, at least 2.
- LINE_WORDS, 4, words per line; power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset (sampled on the clk rising edge; 0 = reset).
- i_commit  in  mem_data_t  store from the buffer: .enable, .address[VA_WIDTH], .data[VA_WIDTH].
- o_hit  out  1  commit hit and word written this cycle.
- o_load  out  1  miss handling in progress (refill or writeback).
- i_rd_addr  in  VA_WIDTH  read-port byte address.
- o_rd_hit  out  1  read-port hit.
- o_rd_data  out  VA_WIDTH  read-port word, valid when o_rd_hit = 1.
- o_mem_req  out  1  memory request, held until acknowledged.
- o_mem_we  out  1  1 = line writeback, 0 = line fetch.
- o_mem_addr  out  VA_WIDTH  line-aligned byte address.
- o_mem_wdata  out  LINE_WORDS*VA_WIDTH  victim line; word 0 in the LSBs.
- i_mem_ack  in  1  one-cycle completion pulse.
- i_mem_rdata  in  LINE_WORDS*VA_WIDTH  fetched line, valid together with i_mem_ack.

Behaviour:
- Address split, LSB first: 2-bit byte offset (ignored; word-aligned accesses), log2(LINE_WORDS) word select, log2(N_SETS) index, remaining bits tag.
- Per line state: valid bit, dirty bit, tag, LINE_WORDS data words.
- FSM states: IDLE, WB, FILL.
- Reset (rst = 0 at an edge), effective next cycle:
  - All valid and dirty bits cleared; state returns to IDLE.
  - o_hit, o_load, o_mem_req and o_mem_we all 0.
  - Any in-flight memory transaction is abandoned; a later i_mem_ack is ignored.
- IDLE with i_commit.enable = 1, lookup is combinational:
  - Hit (valid and tag match): o_hit = 1 and o_load = 0 in the same cycle. At the edge, the word is written and dirty is set.
  - Miss: o_hit = 0 and o_load = 1 in the same cycle. At the edge, the commit line address is latched. Next state is WB if the victim is valid and dirty, otherwise FILL.
- IDLE with i_commit.enable = 0: o_hit = 0, o_load = 0, no state change.
- WB:
  - o_mem_req = 1, o_mem_we = 1.
  - o_mem_addr = {victim tag, index, 0}; o_mem_wdata = victim line.
  - Outputs are stable until i_mem_ack. On ack: clear dirty, go to FILL.
- FILL:
  - o_mem_req = 1, o_mem_we = 0, o_mem_addr = latched line address.
  - On ack: write i_mem_rdata into the line, set tag, valid = 1, dirty = 0; go to IDLE. The commit data is not merged during fill.
- In WB and FILL: o_load = 1 and o_hit = 0, regardless of i_commit.
- Write timing:
  - The store buffer pops one cycle after a registered hit, so the same entry is normally presented again. Its repeated hit rewrites identical data, which is idempotent and allowed.
  - A commit re-presented after FILL hits in the first IDLE cycle; minimum miss penalty is FILL latency + 1 cycle.
- If i_commit.enable drops, or i_commit changes, during WB or FILL, the refill still completes with the latched address. There is no abort.
- i_mem_ack while o_mem_req = 0 is ignored.
- Read port is purely combinational: o_rd_hit = valid and tag match; o_rd_data = the addressed word.
  - During WB and FILL the read port sees pre-refill contents.
  - A read to the word being written in the same cycle returns the old data.
- o_rd_data is 0 when o_rd_hit = 0.

Test Plan:
1. Cold miss, clean victim: after reset, commit {1, 0x100, 0xAAAA_AAAA}, then hold i_commit.
   - Same cycle: o_load = 1, o_hit = 0.
   - Next cycle: FILL with o_mem_req = 1, we = 0, addr = 0x100.
   - Ack with rdata = 0; next cycle o_hit = 1.
   - Following edge: read 0x100 returns 0xAAAA_AAAA.
2. Plain hit: after test 1, commit 0x104 / 0x1234.
   - Same cycle: o_hit = 1, o_load = 0, o_mem_req stays 0.
   - Read 0x104 returns 0x1234; read 0x108 returns 0.
3. Dirty conflict: commit 0x200 / 0x55 (same index as 0x100).
   - WB: we = 1, addr = 0x100, o_mem_wdata[31:0] = 0xAAAA_AAAA, [63:32] = 0x1234.
   - Ack, then FILL at addr = 0x200; ack; then hit.
   - Read 0x100 misses.
4. Slow memory: ack delayed 5 cycles in both WB and FILL.
   - o_mem_req, addr and wdata stay stable and o_load = 1 throughout.
   - An early stray ack while in IDLE has no effect.
5. Reset mid-FILL: drive rst = 0 for one edge.
   - Next cycle: o_mem_req = 0, o_load = 0.
   - Read 0x100 misses; a subsequent i_mem_ack is ignored.
6. Repeated presentation: the same commit held for 2 hit cycles gives a single final value and dirty = 1.
   - Verify by a conflict miss that triggers WB with that value.
